n_queen_solver: RTL and testbench
=================================

Name: n_queen_solver

Overview:
- Parametrised N-queens backtracking engine. It generalises the fixed 8-queen solver to any board size N.
- It enumerates every solution in lexicographic order, streams each one out row by row, then waits for a next/stop handshake before resuming.
- Sits under a top-level wrapper as one self-contained controller and datapath unit, driven by a host FSM or testbench.

Parameters:
- N, 8, board size (rows = columns = queens); legal range 1..16
- COL_W, $clog2(N) (min 1), width of column/row indices; derived, not overridden
- CNT_W, 16, width of solution_count

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a new enumeration; sampled only when ready=1
- next  in  1  in WAIT: resume the search for the next solution
- stop  in  1  in WAIT: abandon the search and go to DONE (next has priority if both are high)
- ready  out  1  high in IDLE and DONE
- done  out  1  high in DONE: search exhausted or stopped
- out_valid  out  1  high while a solution row is on out_bus
- out_row  out  COL_W  row index of the current out_bus word
- out_bus  out  N  one-hot column of the queen in row out_row; zero when out_valid=0
- sol_ready  out  1  high in WAIT (a solution has been fully emitted)
- solution_count  out  CNT_W  see Optional Feature

Behaviour:
- Reset: one clock; reset is synchronous and active-high. It overrides everything, including mid-search and mid-emit. State→IDLE; ready=1; done=0; out_valid=0; out_bus=0; out_row=0; sol_ready=0; row=0; cand=0; solution_count=0; cols[] cleared.
- Registers: cols[0..N-1] (COL_W each), row, cand.
- safe (combinational): for every placed i<row, cand≠cols[i] and |cand−cols[i]|≠row−i.
- IDLE/DONE: start=1 → SEARCH with row=0, cand=0, done=0, count cleared. start is ignored in every other state.
- SEARCH: tests one candidate per cycle.
  - safe and row<N−1: cols[row]←cand, row++, cand←0.
  - safe and row=N−1: cols[row]←cand, count++, go to EMIT with out_row=0.
  - not safe and cand<N−1: cand++.
  - not safe and cand=N−1: go to POP.
- POP: one cycle per level.
  - row=0: go to DONE.
  - cols[row−1]=N−1: row−−, stay in POP.
  - otherwise: row−−, cand←cols[row−1]+1, go to SEARCH.
- EMIT: exactly N consecutive cycles with out_valid=1; out_row steps 0..N−1; out_bus=1<<cols[out_row]. Then go to WAIT.
- WAIT: sol_ready=1 and outputs are held at zero.
  - next=1 → same path as a conflict at row N−1 with cand=cols[N−1]: cand<N−1 → SEARCH with cand+1; else → POP.
  - stop=1 → DONE.
  - Neither: stay in WAIT indefinitely.
- Boundaries:
  - N=1: a single solution (out_bus=1'b1), then DONE after next.
  - N=2 or N=3: no solutions; DONE with no EMIT.
  - Counter arithmetic never wraps: cand and row never exceed N−1 by construction.
- Latency: start accepted at cycle t → first SEARCH evaluation at t+1.

Optional Feature:
- Macro: NQ_SOLUTION_COUNT_EN
- Defined: solution_count increments on each SEARCH→EMIT transition and saturates at 2^CNT_W−1. It is cleared on reset and on accepted start, and holds its value in DONE.
- Undefined: the counter is not built and solution_count is tied to 0.
- All other behaviour is identical in both configurations.

Test Plan:
- N=4, start, answer next at every WAIT:
  - Solution 1 streams out_bus 0010,1000,0001,0100.
  - Solution 2 streams out_bus 0100,0001,1000,0010.
  - After the second next: done=1, solution_count=2.
- N=8, start, next after every solution:
  - First solution cols = 0,4,7,5,2,6,1,3 (out_bus 0x01,0x10,0x80,0x20,0x04,0x40,0x02,0x08).
  - Exactly 92 EMIT bursts; final solution_count=92.
- N=3 and N=2: start → done=1 without ever asserting out_valid; solution_count=0. N=1: one burst with out_bus=1, then done after next.
- N=6, start, at first WAIT assert next=1 and stop=1 together → search continues (next wins). Assert stop alone at the second WAIT → done=1, solution_count=2.
- N=8: reset during EMIT (out_row=3) → next cycle ready=1, out_valid=0, out_bus=0, solution_count=0. Then start → first solution again.
- N=5: start pulsed during SEARCH and during WAIT is ignored. start in DONE restarts the search and clears solution_count; the full run totals 10 solutions.

Source files
------------

// File: rtl/n_queen_solver.sv
// Backtracking N-queens engine: walks every placement in lexicographic order, then
// streams each solution one row per cycle. Optional counter via NQ_SOLUTION_COUNT_EN.
module n_queen_solver #(
    parameter int N     = 8,
    parameter int COL_W = (N > 1) ? $clog2(N) : 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             next,
    input  logic             stop,
    output logic             ready,
    output logic             done,
    output logic             out_valid,
    output logic [COL_W-1:0] out_row,
    output logic [N-1:0]     out_bus,
    output logic             sol_ready,
    output logic [CNT_W-1:0] solution_count
);

    typedef enum logic [2:0] {IDLE, SEARCH, POP, EMIT, WAIT, DONE} state_t;

    localparam logic [COL_W-1:0] LAST = COL_W'(N - 1);

    state_t           state, state_d;
    logic [COL_W-1:0] cols [N];
    logic [COL_W-1:0] row, row_d, cand, cand_d, out_row_d;
    logic [COL_W-1:0] prev;
    logic             col_we, safe;

    // cand conflicts with an already placed queen on its column or a diagonal
    always_comb begin
        safe = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (i < int'(row)) begin
                if (int'(cand) == int'(cols[i]) ||
                    int'(cand) - int'(cols[i]) == int'(row) - i ||
                    int'(cols[i]) - int'(cand) == int'(row) - i)
                    safe = 1'b0;
            end
        end
    end

    assign prev = row - 1'b1;

    always_comb begin
        state_d   = state;
        row_d     = row;
        cand_d    = cand;
        out_row_d = out_row;
        col_we    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SEARCH;
                    row_d   = '0;
                    cand_d  = '0;
                end
            end
            SEARCH: begin
                if (safe) begin
                    col_we = 1'b1;
                    if (row == LAST) begin
                        state_d   = EMIT;
                        out_row_d = '0;
                    end else begin
                        row_d  = row + 1'b1;
                        cand_d = '0;
                    end
                end else if (cand != LAST) begin
                    cand_d = cand + 1'b1;
                end else begin
                    state_d = POP;
                end
            end
            POP: begin
                if (row == '0) begin
                    state_d = DONE;
                end else begin
                    row_d = prev;
                    if (cols[prev] != LAST) begin
                        cand_d  = cols[prev] + 1'b1;
                        state_d = SEARCH;
                    end
                end
            end
            EMIT: begin
                if (out_row == LAST) begin
                    state_d   = WAIT;
                    out_row_d = '0;
                end else begin
                    out_row_d = out_row + 1'b1;
                end
            end
            WAIT: begin
                // resume exactly as if the last-row queen had just conflicted
                if (next) begin
                    if (cand != LAST) begin
                        cand_d  = cand + 1'b1;
                        state_d = SEARCH;
                    end else begin
                        state_d = POP;
                    end
                end else if (stop) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            row     <= '0;
            cand    <= '0;
            out_row <= '0;
            for (int i = 0; i < N; i++) cols[i] <= '0;
        end else begin
            state   <= state_d;
            row     <= row_d;
            cand    <= cand_d;
            out_row <= out_row_d;
            if (col_we) cols[row] <= cand;
        end
    end

    assign ready     = (state == IDLE) || (state == DONE);
    assign done      = (state == DONE);
    assign out_valid = (state == EMIT);
    assign sol_ready = (state == WAIT);
    assign out_bus   = out_valid ? (N'(1) << cols[out_row]) : '0;

`ifdef NQ_SOLUTION_COUNT_EN
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr, cnt_inc;

    assign cnt_clr = ((state == IDLE) || (state == DONE)) && start;
    assign cnt_inc = (state == SEARCH) && safe && (row == LAST);

    always_ff @(posedge clk) begin
        if (reset || cnt_clr)
            cnt <= '0;
        else if (cnt_inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

    assign solution_count = cnt;
`else
    assign solution_count = '0;
`endif

endmodule

// File: tb/tb_n_queen_solver.sv
// Directed bench for n_queen_solver: one instance per board size, table of
// expected solution counts / first solutions plus handshake and reset sequences.
module tb_n_queen_solver;

    localparam int NI = 7;

    function automatic int nsz(input int g);
        case (g)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return 4;
            4: return 5;
            5: return 6;
            default: return 8;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic        st [NI], nx [NI], sp [NI];
    logic        rdy [NI], dn [NI], ov [NI], sr [NI];
    logic [3:0]  orow [NI];
    logic [15:0] ob [NI], cnt [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int NG = nsz(g);
        localparam int CW = (NG > 1) ? $clog2(NG) : 1;
        wire logic [CW-1:0] r_w;
        wire logic [NG-1:0] b_w;
        wire logic [15:0]   c_w;
        wire logic          rdy_w, dn_w, ov_w, sr_w;
        n_queen_solver #(.N(NG)) u_dut (
            .clk(clk), .reset(reset), .start(st[g]), .next(nx[g]), .stop(sp[g]),
            .ready(rdy_w), .done(dn_w), .out_valid(ov_w), .out_row(r_w),
            .out_bus(b_w), .sol_ready(sr_w), .solution_count(c_w)
        );
        assign rdy[g]  = rdy_w;
        assign dn[g]   = dn_w;
        assign ov[g]   = ov_w;
        assign sr[g]   = sr_w;
        assign orow[g] = 4'(r_w);
        assign ob[g]   = 16'(b_w);
        assign cnt[g]  = c_w;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef NQ_SOLUTION_COUNT_EN
        return n;
`else
        return n * 0;
`endif
    endfunction

    function automatic int col_of(input logic [15:0] b);
        int c = -1;
        for (int i = 0; i < 16; i++) if (b == (16'd1 << i)) c = i;
        return c;
    endfunction

    // key holds row 0 in the most significant nibble, so numeric order = lexicographic order
    function automatic bit valid_board(input logic [63:0] key, input int n);
        for (int i = 0; i < n; i++)
            for (int j = i + 1; j < n; j++) begin
                int ci = int'(key[(n-1-i)*4 +: 4]);
                int cj = int'(key[(n-1-j)*4 +: 4]);
                if (ci == cj || ci - cj == j - i || cj - ci == j - i) return 1'b0;
            end
        return 1'b1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin st[k] = 0; nx[k] = 0; sp[k] = 0; end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start(input int k);
        st[k] = 1'b1;
        @(negedge clk);
        st[k] = 1'b0;
    endtask

    task automatic pulse_next(input int k);
        nx[k] = 1'b1;
        @(negedge clk);
        nx[k] = 1'b0;
    endtask

    // follow one instance until it reaches WAIT (got) or DONE (fin), capturing the burst
    task automatic get_sol(input int k, input int n, output logic [63:0] key,
                           output bit got, output bit fin);
        int r = 0;
        key = '0; got = 0; fin = 0;
        for (int cyc = 0; cyc < 60000; cyc++) begin
            @(negedge clk);
            if (ov[k]) begin
                int c = col_of(ob[k]);
                chk($sformatf("n%0d out_row", n), orow[k], r);
                if (c < 0 || c >= n) chk($sformatf("n%0d onehot", n), ob[k], 0);
                key = (key << 4) | 64'(c & 15);
                r++;
            end else if (ob[k] != 0) begin
                chk($sformatf("n%0d bus_idle", n), ob[k], 0);
            end
            if (sr[k]) begin got = 1; break; end
            if (dn[k]) begin fin = 1; break; end
        end
        if (got) chk($sformatf("n%0d burst_len", n), r, n);
        else if (!fin) begin
            chk($sformatf("n%0d timeout", n), 1, 0);
            fin = 1;
        end
    endtask

    // answer next at every WAIT until DONE; checks each board and ordering
    task automatic run_all(input int k, input int n, input int base,
                           output int nsol, output logic [63:0] first);
        logic [63:0] key, last_key;
        bit got, fin;
        nsol = 0; first = '0; last_key = '0;
        for (int s = 0; s < 200; s++) begin
            get_sol(k, n, key, got, fin);
            if (fin) break;
            nsol++;
            if (nsol == 1) first = key;
            chk($sformatf("n%0d sol%0d legal", n, nsol), valid_board(key, n), 1);
            if (nsol > 1) chk($sformatf("n%0d sol%0d order", n, nsol), key > last_key, 1);
            chk($sformatf("n%0d wait_count", n), cnt[k], exp_cnt(base + nsol));
            last_key = key;
            pulse_next(k);
        end
    endtask

    typedef struct {
        int          k;
        int          n;
        int          nsol;
        logic [63:0] first;
    } vec_t;

    vec_t tbl [NI];

    initial begin
        int nsol;
        logic [63:0] first, key;
        bit got, fin;
        bit hit;

        tbl[0] = '{0, 1, 1,  64'h0};
        tbl[1] = '{1, 2, 0,  64'h0};
        tbl[2] = '{2, 3, 0,  64'h0};
        tbl[3] = '{3, 4, 2,  64'h1302};
        tbl[4] = '{4, 5, 10, 64'h02413};
        tbl[5] = '{5, 6, 4,  64'h135024};
        tbl[6] = '{6, 8, 92, 64'h04752613};

        do_reset();
        chk("reset ready", rdy[6], 1);
        chk("reset done", dn[6], 0);
        chk("reset out_valid", ov[6], 0);
        chk("reset out_bus", ob[6], 0);
        chk("reset out_row", orow[6], 0);
        chk("reset sol_ready", sr[6], 0);
        chk("reset count", cnt[6], 0);

        foreach (tbl[t]) begin
            do_reset();
            pulse_start(tbl[t].k);
            chk($sformatf("n%0d busy_after_start", tbl[t].n), rdy[tbl[t].k], 0);
            run_all(tbl[t].k, tbl[t].n, 0, nsol, first);
            chk($sformatf("n%0d nsol", tbl[t].n), nsol, tbl[t].nsol);
            if (tbl[t].nsol > 0) chk($sformatf("n%0d first", tbl[t].n), first, tbl[t].first);
            chk($sformatf("n%0d done", tbl[t].n), dn[tbl[t].k], 1);
            chk($sformatf("n%0d ready", tbl[t].n), rdy[tbl[t].k], 1);
            chk($sformatf("n%0d final_count", tbl[t].n), cnt[tbl[t].k], exp_cnt(tbl[t].nsol));
        end

        // N=6: next and stop together -> next wins; stop alone at the next WAIT
        do_reset();
        pulse_start(5);
        get_sol(5, 6, key, got, fin);
        chk("n6 first_wait", got, 1);
        nx[5] = 1; sp[5] = 1;
        @(negedge clk);
        nx[5] = 0; sp[5] = 0;
        chk("n6 next_wins", dn[5], 0);
        get_sol(5, 6, key, got, fin);
        chk("n6 second_wait", got, 1);
        chk("n6 second_sol", key, 64'h251403);
        sp[5] = 1;
        @(negedge clk);
        sp[5] = 0;
        chk("n6 stop_done", dn[5], 1);
        chk("n6 stop_count", cnt[5], exp_cnt(2));
        @(negedge clk);
        chk("n6 done_holds", dn[5], 1);

        // N=8: reset mid-burst, then a fresh start repeats the first solution
        do_reset();
        pulse_start(6);
        hit = 0;
        for (int cyc = 0; cyc < 60000; cyc++) begin
            @(negedge clk);
            if (ov[6] && orow[6] == 4'd3) begin hit = 1; break; end
        end
        chk("n8 reached_row3", hit, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("n8 rst ready", rdy[6], 1);
        chk("n8 rst out_valid", ov[6], 0);
        chk("n8 rst out_bus", ob[6], 0);
        chk("n8 rst out_row", orow[6], 0);
        chk("n8 rst count", cnt[6], 0);
        reset = 1'b0;
        @(negedge clk);
        pulse_start(6);
        get_sol(6, 8, key, got, fin);
        chk("n8 rst first_again", key, 64'h04752613);

        // N=5: stray start in SEARCH and WAIT is ignored; start in DONE restarts
        do_reset();
        pulse_start(4);
        @(negedge clk);
        pulse_start(4);
        get_sol(4, 5, key, got, fin);
        chk("n5 first_after_stray", key, 64'h02413);
        pulse_start(4);
        chk("n5 start_in_wait", sr[4], 1);
        pulse_next(4);
        run_all(4, 5, 1, nsol, first);
        chk("n5 remaining", nsol, 9);
        chk("n5 done", dn[4], 1);
        pulse_start(4);
        chk("n5 restart_busy", rdy[4], 0);
        chk("n5 restart_count", cnt[4], 0);
        run_all(4, 5, 0, nsol, first);
        chk("n5 rerun_total", nsol, 10);
        chk("n5 rerun_first", first, 64'h02413);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
